// File: rtl/rv_inst_encoder.sv
// RV32I instruction encoder with a small word FIFO that streams encoded
// instructions into instruction memory at consecutive word addresses.
module rv_inst_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_kind,
    input  logic [2:0]        req_funct3,
    input  logic [6:0]        req_funct7,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    input  logic              mem_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic              idle
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [2:0] K_IALU   = 3'b000;
    localparam logic [2:0] K_LOAD   = 3'b001;
    localparam logic [2:0] K_R      = 3'b010;
    localparam logic [2:0] K_JAL    = 3'b011;
    localparam logic [2:0] K_STORE  = 3'b100;
    localparam logic [2:0] K_LUI    = 3'b101;
    localparam logic [2:0] K_BRANCH = 3'b110;
    localparam logic [2:0] K_RSVD   = 3'b111;

    localparam logic [PTR_W:0]    PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_MAX  = {(ADDR_W+1){1'b1}};

    // Branch/JAL offsets are scattered into the word; bit 0 is never encoded.
    function automatic logic [31:0] encode_word(
        input logic [2:0]  kind,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [31:0] w;
        case (kind)
            K_IALU: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    w = {f7, imm[4:0], rs1, f3, rd, 7'b0010011};
                end else begin
                    w = {imm[11:0], rs1, f3, rd, 7'b0010011};
                end
            end
            K_LOAD:   w = {imm[11:0], rs1, f3, rd, 7'b0000011};
            K_R:      w = {f7, rs2, rs1, f3, rd, 7'b0110011};
            K_JAL:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            K_STORE:  w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
            K_LUI:    w = {imm[31:12], rd, 7'b0110111};
            K_BRANCH: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
            default:  w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    logic [31:0]       fifo_q [DEPTH];
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;

    logic [31:0] enc_word_s;
    logic        enc_bad_s;
    logic        full_s;
    logic        empty_s;
    logic        ready_s;
    logic        accept_s;
    logic        push_s;
    logic        pop_s;

    // Encode the current request and flag malformed ones.
    always_comb begin
        enc_word_s = encode_word(req_kind, req_funct3, req_funct7, req_rd,
                                 req_rs1, req_rs2, req_imm);
        enc_bad_s  = 1'b0;
        case (req_kind)
            K_RSVD:            enc_bad_s = 1'b1;
            K_JAL, K_BRANCH:   enc_bad_s = req_imm[0];
            default:           enc_bad_s = 1'b0;
        endcase
    end

    assign full_s   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty_s  = (wr_ptr_q == rd_ptr_q);
    assign ready_s  = !full_s && !start;
    assign accept_s = req_valid && ready_s;
    assign push_s   = accept_s && (req_kind != K_RSVD);
    assign pop_s    = !empty_s && !mem_busy && !start;

    // Next-state for pointers, address, count and error; start overrides all.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        addr_d   = addr_q;
        count_d  = count_q;
        err_d    = err_q;
        if (start) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            addr_d   = start_addr;
            count_d  = '0;
            err_d    = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                addr_d   = addr_q + ADDR_ONE;
                if (count_q != CNT_MAX) begin
                    count_d = count_q + CNT_ONE;
                end else begin
                    count_d = count_q;
                end
            end else begin
                rd_ptr_d = rd_ptr_q;
                addr_d   = addr_q;
                count_d  = count_q;
            end
            if (accept_s && enc_bad_s) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            addr_q   <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            fifo_q[wr_ptr_q[PTR_W-1:0]] <= enc_word_s;
        end
    end

    assign req_ready = ready_s;
    assign mem_we    = pop_s;
    assign mem_addr  = addr_q;
    assign mem_wdata = fifo_q[rd_ptr_q[PTR_W-1:0]];
    assign count     = count_q;
    assign err       = err_q;
    assign idle      = empty_s && !req_valid;

endmodule

// File: tb/tb_rv_inst_encoder.sv
// Scoreboard bench for rv_inst_encoder: expected memory writes are queued at
// request acceptance and compared by a monitor as the DUT drains its FIFO.
module tb_rv_inst_encoder;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_kind;
    logic [2:0]        req_funct3;
    logic [6:0]        req_funct7;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [31:0]       req_imm;
    logic              mem_busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              err;
    logic              idle;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [ADDR_W+31:0] sb_q [$];
    int                 wr_cyc [$];
    logic [ADDR_W-1:0]  exp_addr;
    logic [ADDR_W:0]    exp_count;

    rv_inst_encoder #(.DEPTH(4), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_funct3(req_funct3), .req_funct7(req_funct7), .req_rd(req_rd),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .mem_busy(mem_busy), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .count(count), .err(err), .idle(idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            logic [ADDR_W+31:0] e;
            total++;
            wr_cyc.push_back(cyc);
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected: got addr=%h data=%h, expected no write", mem_addr, mem_wdata);
            end else begin
                e = sb_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    bad++;
                    $display("FAIL wr_data: got addr=%h data=%h, expected addr=%h data=%h",
                             mem_addr, mem_wdata, e[ADDR_W+31:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ialu_word(input logic [11:0] imm, input logic [4:0] rd);
        return {imm, 5'd0, 3'd0, rd, 7'b0010011};
    endfunction

    task automatic do_start(input logic [ADDR_W-1:0] a);
        start      = 1'b1;
        start_addr = a;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb_q.delete();
        exp_addr  = a;
        exp_count = '0;
    endtask

    task automatic push(input logic [2:0] kind, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic [31:0] exp_word, output int waited);
        req_kind = kind; req_funct3 = f3; req_funct7 = f7;
        req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_valid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (req_ready === 1'b1) break;
            waited++;
            if (waited > 200) begin
                total++; bad++;
                $display("FAIL push_timeout: got req_ready=%b for 200 cycles, expected 1", req_ready);
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (kind != 3'b111) begin
            sb_q.push_back({exp_addr, exp_word});
            exp_addr  = exp_addr + 8'd1;
            exp_count = exp_count + 9'd1;
        end
    endtask

    task automatic drain();
        int n = 0;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() == 0 && idle === 1'b1) break;
            n++;
            if (n > 100) begin
                total++; bad++;
                $display("FAIL drain_timeout: got %0d pending writes idle=%b, expected 0 and idle=1", sb_q.size(), idle);
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start_addr = '0; req_valid = 1'b0;
        req_kind = 3'd0; req_funct3 = 3'd0; req_funct7 = 7'd0; req_rd = 5'd0;
        req_rs1 = 5'd0; req_rs2 = 5'd0; req_imm = 32'd0; mem_busy = 1'b0;
        exp_addr = '0; exp_count = '0;
        #1;
        total++;
        if ({mem_we, mem_addr, mem_wdata, count, err, req_ready, idle} !==
            {1'b0, 8'h00, 32'h0, 9'd0, 1'b0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL reset_state: got we=%b addr=%h wdata=%h count=%0d err=%b ready=%b idle=%b, expected 0 00 00000000 0 0 1 1",
                     mem_we, mem_addr, mem_wdata, count, err, req_ready, idle);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_first_word();
        int w;
        do_start(8'h10);
        push(3'b000, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, w);
        @(negedge clk);
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 8'h10) begin
            bad++;
            $display("FAIL first_latency: got we=%b addr=%h, expected we=1 addr=10", mem_we, mem_addr);
        end
        drain();
        total++;
        if (count !== 9'd1) begin
            bad++;
            $display("FAIL first_count: got %0d, expected 1", count);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        int n0;
        do_start(8'h10);
        n0 = wr_cyc.size();
        push(3'b010, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, w);
        push(3'b100, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020A423, w);
        push(3'b101, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, w);
        drain();
        total++;
        if (wr_cyc.size() - n0 != 3 || wr_cyc[n0+2] - wr_cyc[n0] != 2) begin
            bad++;
            $display("FAIL b2b_gapless: got %0d writes spanning %0d cycles, expected 3 spanning 2",
                     wr_cyc.size() - n0, wr_cyc[wr_cyc.size()-1] - wr_cyc[n0]);
        end
        total++;
        if (count !== exp_count || count !== 9'd3) begin
            bad++;
            $display("FAIL b2b_count: got %0d, expected 3", count);
        end
    endtask

    task automatic test_jal_branch();
        int w;
        push(3'b011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 32'h008000EF, w);
        push(3'b110, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE208EE3, w);
        drain();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL jal_branch_err: got err=%b, expected 0", err);
        end
    endtask

    task automatic test_busy();
        int w;
        logic [ADDR_W:0] base;
        base = exp_count;
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(3'b000, 3'd0, 7'd0, 5'(i + 4), 5'd0, 5'd0, 32'(i + 16),
                 ialu_word(12'(i + 16), 5'(i + 4)), w);
        end
        @(negedge clk);
        total++;
        if (req_ready !== 1'b0 || mem_we !== 1'b0 || count !== base) begin
            bad++;
            $display("FAIL busy_full: got ready=%b we=%b count=%0d, expected ready=0 we=0 count=%0d",
                     req_ready, mem_we, count, base);
        end
        @(posedge clk);
        #1;
        mem_busy = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_pop_ready: got ready=%b in popping cycle, expected 0", req_ready);
        end
        push(3'b001, 3'b010, 7'd0, 5'd9, 5'd3, 5'd0, 32'h0000_0FFC, 32'hFFC1A483, w);
        total++;
        if (w != 0) begin
            bad++;
            $display("FAIL ready_rise: got %0d wait cycles, expected 0", w);
        end
        drain();
        total++;
        if (count !== exp_count) begin
            bad++;
            $display("FAIL busy_count: got %0d, expected %0d", count, exp_count);
        end
    endtask

    task automatic test_err();
        int w;
        push(3'b111, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0, 32'd0, w);
        drain();
        total++;
        if (err !== 1'b1 || count !== exp_count) begin
            bad++;
            $display("FAIL rsvd_kind: got err=%b count=%0d, expected err=1 count=%0d", err, count, exp_count);
        end
        push(3'b110, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 32'h00208163, w);
        drain();
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL odd_branch_err: got err=%b, expected 1", err);
        end
        do_start(8'h20);
        @(negedge clk);
        total++;
        if (err !== 1'b0 || count !== 9'd0 || mem_addr !== 8'h20) begin
            bad++;
            $display("FAIL start_clear: got err=%b count=%0d addr=%h, expected 0 0 20", err, count, mem_addr);
        end
    endtask

    task automatic test_start_flush();
        int w;
        mem_busy = 1'b1;
        push(3'b000, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd7, ialu_word(12'd7, 5'd2), w);
        push(3'b000, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd9, ialu_word(12'd9, 5'd3), w);
        mem_busy   = 1'b0;
        start      = 1'b1;
        start_addr = 8'h40;
        req_valid  = 1'b1;
        @(negedge clk);
        total++;
        if (mem_we !== 1'b0 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL start_priority: got we=%b ready=%b, expected 0 0", mem_we, req_ready);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        req_valid = 1'b0;
        sb_q.delete();
        exp_addr = 8'h40;
        exp_count = '0;
        @(negedge clk);
        total++;
        if (idle !== 1'b1 || mem_we !== 1'b0 || count !== 9'd0 || mem_addr !== 8'h40) begin
            bad++;
            $display("FAIL start_flush: got idle=%b we=%b count=%0d addr=%h, expected 1 0 0 40",
                     idle, mem_we, count, mem_addr);
        end
    endtask

    task automatic test_wrap_reset();
        int w;
        do_start(8'hFF);
        push(3'b000, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0, 32'd1, ialu_word(12'd1, 5'd6), w);
        push(3'b000, 3'b101, 7'b0100000, 5'd7, 5'd6, 5'd0, 32'd3, 32'h40335393, w);
        drain();
        total++;
        if (count !== 9'd2 || mem_addr !== 8'h01) begin
            bad++;
            $display("FAIL wrap: got count=%0d addr=%h, expected 2 01", count, mem_addr);
        end
        mem_busy = 1'b1;
        push(3'b000, 3'd0, 7'd0, 5'd8, 5'd0, 5'd0, 32'd2, ialu_word(12'd2, 5'd8), w);
        push(3'b000, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'd4, ialu_word(12'd4, 5'd9), w);
        mem_busy = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (mem_we !== 1'b0 || count !== 9'd0 || mem_addr !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid: got we=%b count=%0d addr=%h, expected 0 0 00", mem_we, count, mem_addr);
        end
        sb_q.delete();
        exp_addr = '0;
        exp_count = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        total++;
        if (idle !== 1'b1 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got idle=%b we=%b, expected 1 0", idle, mem_we);
        end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_back_to_back();
        test_jal_branch();
        test_busy();
        test_err();
        test_start_flush();
        test_wrap_reset();
        repeat (3) @(posedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d unwritten words, expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_inst_encoder.md
# rv_inst_encoder

Instruction encoder and program writer for the RISC-V-ISA core: it is the write-side counterpart of the control-unit decode path. Each accepted request carries an instruction class plus register, funct and immediate fields. The block packs it into a 32-bit RV32I word and buffers it in a small FIFO. It then streams the words into instruction memory at consecutive word addresses. Test benches and the boot loader use it to build programs that the core then fetches and decodes.

## Interface
- DEPTH, 4: FIFO entries, power of two, at least 2.
- ADDR_W, 8: instruction-memory word-address width.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle pulse: flush the FIFO, load the address, clear err and count.
- start_addr  in  ADDR_W  first word address, sampled when start=1.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted on an edge where req_valid and req_ready are both 1.
- req_kind  in  3  instruction class, encoded below.
- req_funct3  in  3  funct3 field.
- req_funct7  in  7  funct7 field (R-type and I-type shifts).
- req_rd  in  5  rd field.
- req_rs1  in  5  rs1 field.
- req_rs2  in  5  rs2 field.
- req_imm  in  32  raw immediate; byte offset for branch and JAL, upper 20 bits for LUI.
- mem_busy  in  1  memory stall.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written since start/reset, saturating.
- err  out  1  sticky error flag.
- idle  out  1  FIFO empty and no request pending.

## Operation
- req_kind encoding and output word:
  - 000 I-ALU: op 0010011, imm[11:0] rs1 f3 rd op. For f3=001/101, bits 31:25 = funct7 and bits 24:20 = imm[4:0].
  - 001 LOAD: op 0000011, I format.
  - 010 R: funct7 rs2 rs1 f3 rd 0110011.
  - 011 JAL: imm[20|10:1|11|19:12] rd 1101111.
  - 100 STORE: imm[11:5] rs2 rs1 f3 imm[4:0] 0100011.
  - 101 LUI: imm[31:12] rd 0110111.
  - 110 BRANCH: imm[12|10:5] rs2 rs1 f3 imm[4:1|11] 1100011.
  - 111: reserved.
- Encoding is combinational. An accepted request pushes its word into the FIFO on the acceptance edge.
- Kind 111 is accepted (consumed) but not pushed, and it sets err.
- For JAL or BRANCH with req_imm[0]=1: the word is pushed with bit 0 dropped, and err is set.
- Immediate bits beyond the field width are truncated silently.
- Drain rule: mem_we = !empty && !mem_busy. mem_wdata is the FIFO head and mem_addr is the address counter.
- Each cycle with mem_we=1: pop the head, increment the address, increment count (saturating at all-ones).
- The address counter wraps from 2^ADDR_W-1 to 0 with no error.
- req_ready = !full && !start. A push is refused when full, even if a pop happens in the same cycle.
- On a cycle where full and not busy, the pop frees a slot, so ready rises the following cycle.
- start has priority over everything else:
  - mem_we is forced 0 that cycle.
  - Any request in that cycle is not accepted.
  - FIFO pointers, err and count are cleared; address = start_addr.
- Simultaneous push and pop when not full: both occur and occupancy is unchanged.

## Timing
- Reset (async assert, sync-safe release) sets all outputs:
  - mem_we=0, mem_addr=0, mem_wdata=0 (FIFO head storage cleared).
  - count=0, err=0, req_ready=1, idle=1.
  - FIFO empty.
- Latency: request accepted at edge E → mem_we=1 during the cycle after E if the FIFO was empty and mem_busy=0 → written at edge E+1.
- Sustained throughput is one word per cycle with mem_busy=0.
- mem_busy asserted holds head, address and count unchanged; words are neither lost nor duplicated.
- err is set at the acceptance edge and stays set until start or reset.
- rst_n asserted mid-stream discards the FIFO contents immediately.

## Test plan
- start with start_addr=0x10; push I-ALU f3=0 rd=1 rs1=0 imm=5 → mem_we at addr 0x10, wdata 0x00500093, count=1.
- Push back-to-back, one per cycle:
  - R f3=0 f7=0 rd=3 rs1=1 rs2=2 → 0x002081B3 at addr 0x10.
  - STORE f3=010 rs1=1 rs2=2 imm=8 → 0x0020A423 at addr 0x11.
  - LUI rd=5 imm=0x12345000 → 0x123452B7 at addr 0x12.
  - Expect consecutive writes with no gaps.
- JAL rd=1 imm=8 → 0x008000EF; BRANCH f3=0 rs1=1 rs2=2 imm=-4 → 0xFE208EE3; err stays 0.
- Hold mem_busy=1 and push 5 requests → req_ready low after 4 (DEPTH=4). Release → 4 writes at consecutive addresses, then the 5th is accepted.
- kind=111 → no write, err=1. Then BRANCH imm=3 → written, err stays 1. Then start → err=0, count=0.
- start_addr=0xFF, push 2 → writes at 0xFF then 0x00. Assert rst_n low mid-drain → mem_we=0 immediately and idle=1 after release.
